// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundle of the two requester ports, the two response ports,
// the shared-ALU side and the busy flag. The arbiter uses the slave modport;
// the environment (requesters plus the combinational ALU) uses master.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer happens
// on a rising clk edge where valid && ready are both high. Neither side may
// make valid depend on ready. The arbiter's ready outputs are combinational in
// the IDLE state only; rsp data/zero are held stable while rsp valid is high
// and not yet accepted.
interface alu_arbiter_if;
  // requester 0
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_ctl;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_data;
  logic        rsp0_zero;
  // requester 1
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_ctl;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_data;
  logic        rsp1_zero;
  // shared combinational ALU
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;
  // status
  logic        busy;

  modport slave (
    input  req0_valid, req0_ctl, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_ctl, req1_a, req1_b, rsp1_ready,
    input  alu_out, alu_zero,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_zero,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_zero,
    output alu_ctl, alu_a, alu_b,
    output busy
  );

  modport master (
    output req0_valid, req0_ctl, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_ctl, req1_a, req1_b, rsp1_ready,
    output alu_out, alu_zero,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_zero,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_zero,
    input  alu_ctl, alu_a, alu_b,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// One operation is in flight at a time: IDLE (arbitrate/accept) -> EXEC (ALU
// evaluates registered operands) -> RESP (result held until consumed).
// Optional feature macro: ALU_ARB_RR_EN selects round-robin arbitration;
// without it req0 has fixed priority and no last-grant state exists.
// o_dbg_state exposes the FSM encoding (0 IDLE, 1 EXEC, 2 RESP).
module alu_arbiter (
  input  logic               clk,
  input  logic               rst_n,
  alu_arbiter_if.slave       bus,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  // operand registers feeding the ALU, result registers feeding responses
  logic [3:0]  r_ctl;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_res;
  logic        r_zero;
  // requester that owns the in-flight operation (0 or 1)
  logic        r_gnt;

  logic        w_any;
  logic        w_grant;
  logic        w_accept;
  logic        w_rsp_ready_g;
  logic        w_done;
  logic [3:0]  w_sel_ctl;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;

`ifdef ALU_ARB_RR_EN
  // requester granted on the most recent accept; resets to 1 so req0 goes first
  logic        r_last;
`endif

  assign w_any = bus.req0_valid | bus.req1_valid;

`ifdef ALU_ARB_RR_EN
  // Round-robin pick: contention goes to whoever was not granted last;
  // a lone requester always wins.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant = ~r_last;
    end else begin
      w_grant = bus.req1_valid;
    end
  end
`else
  // Fixed priority: req1 is picked only when req0 is absent.
  assign w_grant = ~bus.req0_valid;
`endif

  assign w_accept      = (r_state == ST_IDLE) && w_any;
  assign w_rsp_ready_g = r_gnt ? bus.rsp1_ready : bus.rsp0_ready;
  assign w_done        = (r_state == ST_RESP) && w_rsp_ready_g;

  assign w_sel_ctl = w_grant ? bus.req1_ctl : bus.req0_ctl;
  assign w_sel_a   = w_grant ? bus.req1_a   : bus.req0_a;
  assign w_sel_b   = w_grant ? bus.req1_b   : bus.req0_b;

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: EXEC always lasts one cycle, RESP waits for the owner's ready.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any)  w_next_state = ST_EXEC;
      ST_EXEC:             w_next_state = ST_RESP;
      ST_RESP: if (w_done) w_next_state = ST_IDLE;
      default:             w_next_state = ST_IDLE;
    endcase
  end

  // Outputs: ready only in IDLE for the granted side, response only in RESP
  // for the owner; the other requester sees zeros.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp0_data  = '0;
    bus.rsp1_data  = '0;
    bus.rsp0_zero  = 1'b0;
    bus.rsp1_zero  = 1'b0;
    bus.busy       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        bus.req0_ready = w_any && !w_grant;
        bus.req1_ready = w_any &&  w_grant;
      end
      ST_RESP: begin
        if (r_gnt) begin
          bus.rsp1_valid = 1'b1;
          bus.rsp1_data  = r_res;
          bus.rsp1_zero  = r_zero;
        end else begin
          bus.rsp0_valid = 1'b1;
          bus.rsp0_data  = r_res;
          bus.rsp0_zero  = r_zero;
        end
      end
      default: begin
      end
    endcase
  end

  // Operand capture on accept; the ALU only ever sees these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_gnt <= 1'b0;
    end else if (w_accept) begin
      r_ctl <= w_sel_ctl;
      r_a   <= w_sel_a;
      r_b   <= w_sel_b;
      r_gnt <= w_grant;
    end
  end

`ifdef ALU_ARB_RR_EN
  // Last-grant tracking, updated on every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_grant;
    end
  end
`endif

  // Result capture at the closing edge of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res  <= '0;
      r_zero <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_res  <= bus.alu_out;
      r_zero <= bus.alu_zero;
    end
  end

  assign bus.alu_ctl = r_ctl;
  assign bus.alu_a   = r_a;
  assign bus.alu_b   = r_b;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives two requesters with directed and random operations,
// provides a behavioural ALU, and checks grants, latency, response data and
// reset behaviour against a transaction-level reference model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  dbg_state;

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int last_g   = 1;          // model of last grant (only consulted when RR)
  logic [32:0] exp_q[$];     // {zero, data} expected per accepted operation

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference ALU ({zero, result}) ----------------
  function automatic logic [32:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (c)
      4'd2:    r = a + b;
      4'd0:    r = a & b;
      4'd12:   r = ~(a | b);
      4'd1:    r = a | b;
      4'd7:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    r = a - b;
      4'd13:   r = a ^ b;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // the shared combinational ALU seen by the DUT
  always_comb begin
    {bus.alu_zero, bus.alu_out} = alu_ref(bus.alu_ctl, bus.alu_a, bus.alu_b);
  end

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_ctl = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_ctl = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  function automatic int model_grant(input logic v0, input logic v1);
    if (v0 && v1) return RR ? (1 - last_g) : 0;
    return v1 ? 1 : 0;
  endfunction

  // One complete operation: present (v0,v1), check grant, EXEC, RESP held for
  // 'hold' cycles, then handshake. Returns the observed {zero, data}.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                        input int hold, output logic [32:0] got);
    int g;
    logic [32:0] exp;
    logic [1:0]  exp_rdy;
    logic [43:0] exp_alu;
    g = model_grant(v0, v1);
    exp_rdy = (g == 1) ? 2'b10 : 2'b01;
    exp_alu = (g == 1) ? {c1, a1[19:0], b1[19:0]} : {c0, a0[19:0], b0[19:0]};
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_ctl = c0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_ctl = c1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    #1;
    n_checks++;
    if ({bus.req1_ready, bus.req0_ready} !== exp_rdy) begin
      n_errors++;
      $display("FAIL grant: ready={r1,r0}=%b required %b", {bus.req1_ready, bus.req0_ready}, exp_rdy);
    end
    exp_q.push_back((g == 1) ? alu_ref(c1, a1, b1) : alu_ref(c0, a0, b0));
    last_g = g;
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #1;
    n_checks++;
    if (!(bus.busy === 1'b1 && bus.req0_ready === 1'b0 && bus.req1_ready === 1'b0 &&
          bus.rsp0_valid === 1'b0 && bus.rsp1_valid === 1'b0 &&
          {bus.alu_ctl, bus.alu_a[19:0], bus.alu_b[19:0]} === exp_alu)) begin
      n_errors++;
      $display("FAIL exec_cycle: busy=%b rdy=%b%b rspv=%b%b alu=%h required busy=1 rdy=00 rspv=00 alu=%h",
               bus.busy, bus.req1_ready, bus.req0_ready, bus.rsp1_valid, bus.rsp0_valid,
               {bus.alu_ctl, bus.alu_a[19:0], bus.alu_b[19:0]}, exp_alu);
    end
    @(negedge clk);
    #1;
    exp = exp_q.pop_front();
    got = (g == 1) ? {bus.rsp1_zero, bus.rsp1_data} : {bus.rsp0_zero, bus.rsp0_data};
    n_checks++;
    if (!({bus.rsp1_valid, bus.rsp0_valid} === exp_rdy && got === exp)) begin
      n_errors++;
      $display("FAIL response: rspv={v1,v0}=%b zero/data=%h required %b / %h",
               {bus.rsp1_valid, bus.rsp0_valid}, got, exp_rdy, exp);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (!({bus.rsp1_valid, bus.rsp0_valid} === exp_rdy && bus.busy === 1'b1 &&
            ((g == 1) ? {bus.rsp1_zero, bus.rsp1_data} : {bus.rsp0_zero, bus.rsp0_data}) === exp)) begin
        n_errors++;
        $display("FAIL resp_hold: cycle %0d rspv=%b busy=%b required rspv=%b busy=1 data=%h",
                 i, {bus.rsp1_valid, bus.rsp0_valid}, bus.busy, exp_rdy, exp);
      end
    end
    @(negedge clk);
    if (g == 1) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    #1;
    n_checks++;
    if (!(bus.busy === 1'b0 && bus.rsp0_valid === 1'b0 && bus.rsp1_valid === 1'b0)) begin
      n_errors++;
      $display("FAIL back_to_idle: busy=%b rspv=%b%b required 0 00", bus.busy,
               bus.rsp1_valid, bus.rsp0_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_g = 1;
  endtask

  task automatic check_all_zero(input string tag);
    logic [142:0] v;
    v = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
         bus.rsp0_data, bus.rsp1_data, bus.rsp0_zero, bus.rsp1_zero,
         bus.alu_ctl, bus.alu_a, bus.alu_b, bus.busy, dbg_state};
    n_checks++;
    if (v !== '0) begin
      n_errors++;
      $display("FAIL %s: outputs=%h required all zero", tag, v);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("after_release");
  endtask

  task automatic test_basic();
    logic [32:0] got;
    run_op(1'b1, 1'b0, 4'd2, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 0, got);
    n_checks++;
    if (got !== {1'b0, 32'd12}) begin
      n_errors++;
      $display("FAIL add_5_7: got %h required %h", got, {1'b0, 32'd12});
    end
    run_op(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 4'd6, 32'h10, 32'h10, 1, got);
    n_checks++;
    if (got !== {1'b1, 32'd0}) begin
      n_errors++;
      $display("FAIL sub_equal: got %h required %h", got, {1'b1, 32'd0});
    end
    run_op(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 4'd7, 32'hFFFF_FFFF, 32'd1, 0, got);
    n_checks++;
    if (got !== {1'b0, 32'd1}) begin
      n_errors++;
      $display("FAIL slt_signed: got %h required %h", got, {1'b0, 32'd1});
    end
    run_op(1'b1, 1'b0, 4'd9, 32'h1234, 32'h5678, 4'd0, 32'd0, 32'd0, 0, got);
    n_checks++;
    if (got !== {1'b1, 32'd0}) begin
      n_errors++;
      $display("FAIL undefined_ctl: got %h required %h", got, {1'b1, 32'd0});
    end
  endtask

  // Both requesters held valid with rsp_ready high from reset.
  task automatic test_arb_order();
    int n_acc;
    int g_exp;
    int g_obs;
    apply_reset();
    n_acc = 0;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_ctl = 4'd2; bus.req0_a = 32'd100; bus.req0_b = 32'd1;
    bus.req1_valid = 1'b1; bus.req1_ctl = 4'd1; bus.req1_a = 32'hF0;  bus.req1_b = 32'h0F;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
        g_exp = RR ? (1 - last_g) : 0;
        g_obs = bus.req1_ready ? 1 : 0;
        n_checks++;
        if (g_obs != g_exp || (bus.req0_ready && bus.req1_ready)) begin
          n_errors++;
          $display("FAIL arb_order: accept %0d granted %0d required %0d", n_acc, g_obs, g_exp);
        end
        last_g = g_exp;
        n_acc++;
      end
      if (bus.rsp0_valid === 1'b1) begin
        n_checks++;
        if ({bus.rsp0_zero, bus.rsp0_data} !== alu_ref(4'd2, 32'd100, 32'd1)) begin
          n_errors++;
          $display("FAIL arb_rsp0: got %h required %h", {bus.rsp0_zero, bus.rsp0_data},
                   alu_ref(4'd2, 32'd100, 32'd1));
        end
      end
      if (bus.rsp1_valid === 1'b1) begin
        n_checks++;
        if ({bus.rsp1_zero, bus.rsp1_data} !== alu_ref(4'd1, 32'hF0, 32'h0F)) begin
          n_errors++;
          $display("FAIL arb_rsp1: got %h required %h", {bus.rsp1_zero, bus.rsp1_data},
                   alu_ref(4'd1, 32'hF0, 32'h0F));
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    n_checks++;
    if (n_acc != 4) begin
      n_errors++;
      $display("FAIL arb_accept_count: got %0d required 4", n_acc);
    end
  endtask

  // rsp0 back-pressured for 5 cycles while req1 waits.
  task automatic test_back_to_back();
    logic [32:0] exp;
    bit ok;
    exp = alu_ref(4'd13, 32'hAAAA_5555, 32'h0F0F_0F0F);
    @(negedge clk);
    idle_inputs();
    bus.req0_valid = 1'b1; bus.req0_ctl = 4'd13; bus.req0_a = 32'hAAAA_5555; bus.req0_b = 32'h0F0F_0F0F;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_accept0: req0_ready=%b required 1", bus.req0_ready);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_ctl = 4'd12; bus.req1_a = 32'h0000_FFFF; bus.req1_b = 32'h00FF_0000;
    #1;
    ok = (bus.req1_ready === 1'b0) && (bus.busy === 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      ok = ok && bus.req1_ready === 1'b0 && bus.busy === 1'b1 && bus.rsp0_valid === 1'b1 &&
           {bus.rsp0_zero, bus.rsp0_data} === exp;
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL bp_hold: last rsp0=%h rdy1=%b busy=%b required rsp0=%h rdy1=0 busy=1",
               {bus.rsp0_zero, bus.rsp0_data}, bus.req1_ready, bus.busy, exp);
    end
    @(negedge clk);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    n_checks++;
    if (!(bus.req1_ready === 1'b1 && bus.req0_ready === 1'b0 && bus.busy === 1'b0)) begin
      n_errors++;
      $display("FAIL bp_accept1: rdy1=%b rdy0=%b busy=%b required 1 0 0",
               bus.req1_ready, bus.req0_ready, bus.busy);
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (!(bus.rsp1_valid === 1'b1 &&
          {bus.rsp1_zero, bus.rsp1_data} === alu_ref(4'd12, 32'h0000_FFFF, 32'h00FF_0000))) begin
      n_errors++;
      $display("FAIL bp_rsp1: v=%b got %h required %h", bus.rsp1_valid,
               {bus.rsp1_zero, bus.rsp1_data}, alu_ref(4'd12, 32'h0000_FFFF, 32'h00FF_0000));
    end
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
    last_g = 1;
  endtask

  // Reset pulse while an operation is in EXEC.
  task automatic test_reset_in_exec();
    logic [32:0] got;
    bit quiet;
    @(negedge clk);
    idle_inputs();
    bus.req0_valid = 1'b1; bus.req0_ctl = 4'd2; bus.req0_a = 32'd3; bus.req0_b = 32'd4;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_exec_busy: busy=%b required 1", bus.busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_exec");
    @(negedge clk);
    rst_n = 1'b1;
    last_g = 1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      quiet = quiet && bus.rsp0_valid === 1'b0 && bus.rsp1_valid === 1'b0 && bus.busy === 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_errors++;
      $display("FAIL rst_no_response: rspv=%b%b busy=%b required 00 0",
               bus.rsp1_valid, bus.rsp0_valid, bus.busy);
    end
    run_op(1'b1, 1'b0, 4'd13, 32'hF0, 32'hFF, 4'd0, 32'd0, 32'd0, 0, got);
    n_checks++;
    if (got !== {1'b0, 32'h0F}) begin
      n_errors++;
      $display("FAIL xor_after_reset: got %h required %h", got, {1'b0, 32'h0F});
    end
  endtask

  task automatic test_random();
    logic [32:0] got;
    logic [3:0]  ctl_tbl [8];
    logic [1:0]  vv;
    ctl_tbl = '{4'd2, 4'd0, 4'd12, 4'd1, 4'd7, 4'd6, 4'd13, 4'd15};
    for (int i = 0; i < 24; i++) begin
      vv = 2'($urandom_range(1, 3));
      run_op(vv[0], vv[1],
             ctl_tbl[$urandom_range(0, 7)], $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
             ctl_tbl[$urandom_range(0, 7)], $urandom, $urandom,
             $urandom_range(0, 3), got);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_arb_order();
    test_back_to_back();
    test_reset_in_exec();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
